// File: rtl/parity_pkg.sv
// Shared constants and helpers for the switch parity monitor and its button debouncers.
package parity_pkg;

    localparam int CLK_HZ           = 100000000;
    localparam int DEBOUNCE_MS      = 10;
    localparam int DEBOUNCE_CYC_DEF = CLK_HZ / 1000 * DEBOUNCE_MS;

    // Counter must be able to hold DEBOUNCE_CYC-1; never narrower than one bit.
    function automatic int debounceCntW(input int cyc);
        return (cyc < 1) ? 1 : $clog2(cyc + 1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: synchroniser, stable-level debounce counter and a
// registered one-cycle pulse on each accepted press (rising debounced level).
module btn_debounce
    import parity_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic level,
    output logic rise
);

    localparam int            CW       = debounceCntW(DEBOUNCE_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic [SYNC_STAGES-1:0] syncChain;
    logic                   btnS;
    logic [CW-1:0]          stableCnt;
    logic                   flip;

    assign btnS = syncChain[SYNC_STAGES-1];
    assign flip = (btnS != level) && (stableCnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            syncChain <= '0;
            stableCnt <= '0;
            level     <= 1'b0;
            rise      <= 1'b0;
        end else begin
            syncChain <= {syncChain[SYNC_STAGES-2:0], btn_raw};
            // Pulse is registered alongside the level flip so it lands in the cycle after.
            rise      <= flip && !level;
            if (btnS == level) begin
                stableCnt <= '0;
            end else if (flip) begin
                stableCnt <= '0;
                level     <= ~level;
            end else begin
                stableCnt <= stableCnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/parity_monitor.sv
// Switch-word parity generator with debounced capture/clear buttons feeding a
// running parity accumulator, saturating capture counter and sticky error flag.
module parity_monitor
    import parity_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int CNT_W        = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] sw,
    input  logic              odd_sel,
    input  logic              btn_cap,
    input  logic              btn_clr,
    output logic              par_word,
    output logic              par_acc,
    output logic [CNT_W-1:0]  word_cnt,
    output logic              err
);

    logic [DATA_W-1:0]      swSync [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] oddSync;
    logic [DATA_W-1:0]      swS;
    logic                   oddS;
    logic                   wordPar;
    logic                   capP;
    logic                   clrP;
    logic                   unusedCapLevel;
    logic                   unusedClrLevel;

    assign swS     = swSync[SYNC_STAGES-1];
    assign oddS    = oddSync[SYNC_STAGES-1];
    assign wordPar = ^swS;

    btn_debounce #(
        .SYNC_STAGES  (SYNC_STAGES),
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) uCapDebounce (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_cap),
        .level   (unusedCapLevel),
        .rise    (capP)
    );

    btn_debounce #(
        .SYNC_STAGES  (SYNC_STAGES),
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) uClrDebounce (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_clr),
        .level   (unusedClrLevel),
        .rise    (clrP)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) swSync[i] <= '0;
            oddSync <= '0;
        end else begin
            swSync[0] <= sw;
            for (int i = 1; i < SYNC_STAGES; i++) swSync[i] <= swSync[i-1];
            oddSync <= {oddSync[SYNC_STAGES-2:0], odd_sel};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_word <= 1'b0;
            par_acc  <= 1'b0;
            word_cnt <= '0;
            err      <= 1'b0;
        end else begin
            par_word <= wordPar ^ oddS;
            // Clear has priority; a capture landing on the same edge is dropped.
            if (clrP) begin
                par_acc  <= 1'b0;
                word_cnt <= '0;
                err      <= 1'b0;
            end else if (capP) begin
                par_acc <= par_acc ^ wordPar;
                if (word_cnt != '1) word_cnt <= word_cnt + CNT_W'(1);
                err     <= err | (wordPar != oddS);
            end
        end
    end

endmodule

// File: doc/parity_monitor.md
# parity_monitor

Parametrised, clocked successor to the board-level switch parity logic. It synchronises a DATA_W-bit switch word and the mode input, and generates an even/odd parity bit for the live word. Two debounced push-buttons capture words into a running parity accumulator with a saturating word counter and a sticky parity-error flag. It sits between the Basys3 switch/button pins and the LED drivers.

## Interface
- DATA_W, 8: switch word width; minimum 2.
- SYNC_STAGES, 2: flip-flops per input synchroniser; minimum 2.
- DEBOUNCE_CYC, 1000000: consecutive stable cycles required before a button level is accepted (10 ms at 100 MHz); minimum 1.
- CNT_W, 8: width of the captured-word counter.
- clk  in  1  100 MHz board clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- sw  in  DATA_W  raw switch word; asynchronous to clk.
- odd_sel  in  1  raw mode switch: 0 = even parity, 1 = odd parity.
- btn_cap  in  1  raw capture button; active-high; bouncy.
- btn_clr  in  1  raw clear button; active-high; bouncy.
- par_word  out  1  parity bit for the current synchronised word.
- par_acc  out  1  XOR of the raw parities (^word) of all words captured since the last clear.
- word_cnt  out  CNT_W  number of captures since the last clear; saturating.
- err  out  1  sticky: a captured word failed the parity check for the current mode.

## Operation
- Every output, every synchroniser stage, every debounce counter and every debounced level resets to 0.
- sw and odd_sel each pass through a SYNC_STAGES synchroniser, giving sw_s and odd_s.
- par_word is registered each cycle as ^sw_s ^ odd_s.
  - Even mode: the bit that makes the total count of ones even.
  - Odd mode: the bit that makes the total count of ones odd.
- Each button passes through its own synchroniser and debouncer:
  - Counter increments while the synchronised level differs from the debounced level.
  - Counter clears to 0 whenever the two are equal.
  - When the counter reaches DEBOUNCE_CYC-1 and the levels still differ, the debounced level flips and the counter clears.
  - A rising edge of the debounced level produces a one-cycle pulse (cap_p / clr_p). Falling edges produce no pulse.
- On a clock edge with cap_p=1 and clr_p=0:
  - par_acc <= par_acc ^ (^sw_s).
  - word_cnt <= word_cnt+1, holding at 2^CNT_W-1 once saturated.
  - err <= err | ((^sw_s) != odd_s). The captured word is treated as data plus its own parity bit.
- On a clock edge with clr_p=1: par_acc, word_cnt and err are cleared. Clear wins over a simultaneous capture, and that capture is discarded.
- When word_cnt is saturated, a capture still updates par_acc and err.
- A change to odd_sel between captures does not alter err retroactively. Only later captures use the new mode.
- Reset mid-operation clears all state immediately. A button held through reset deassertion must still complete a full debounce and then produces exactly one pulse.

## Timing
- sw or odd_sel change at edge 0 → par_word updated at edge SYNC_STAGES+1.
- Clean button press at edge 0 → debounced level high at edge SYNC_STAGES+DEBOUNCE_CYC → pulse high for the following cycle → par_acc, word_cnt and err updated at edge SYNC_STAGES+DEBOUNCE_CYC+1.
- A bounce shorter than DEBOUNCE_CYC cycles produces no pulse.
- A held button produces exactly one pulse per press.
- Release-then-press requires DEBOUNCE_CYC stable low cycles before the next press is accepted.
- Throughput: at most one capture per 2·DEBOUNCE_CYC cycles.

## Structure
- Shared package parity_pkg holds:
  - constant CLK_HZ = 100000000;
  - constant DEBOUNCE_MS = 10, with DEBOUNCE_CYC defaulting to CLK_HZ/1000·DEBOUNCE_MS;
  - a function computing the counter width as $clog2(DEBOUNCE_CYC+1).
- Sub-module btn_debounce (parameters SYNC_STAGES, DEBOUNCE_CYC; ports clk, rst_n, btn_raw, level, rise) contains synchroniser, debounce counter and rise detector. It is instantiated twice.
- The switch word synchroniser and the parity/accumulator logic stay in the top level.

## Test plan
Simulation uses DATA_W=8, SYNC_STAGES=2, DEBOUNCE_CYC=4, CNT_W=2.
- Parity generation: sw=8'b1011_0000, odd_sel=0 → par_word=1 at edge 3. Then odd_sel=1 → par_word=0 three edges later.
- Capture accumulation: even mode, capture 8'h03 then 8'h07 with clean presses → word_cnt=1 after the first capture and 2 after the second; par_acc=0 after the first and 1 after the second; err=0 after the first and 1 after the second.
- Bounce rejection:
  - btn_cap toggles every 2 cycles for 20 cycles, then goes low → no pulse and word_cnt unchanged.
  - A 6-cycle press → exactly one capture.
- Saturation and clear:
  - Five captures → word_cnt holds at 3, and par_acc reflects all 5 words.
  - btn_cap and btn_clr pressed on the same cycle → word_cnt=0, par_acc=0, err=0.
- Reset mid-debounce: assert rst_n=0 two cycles into a btn_cap press, then release with the button held → all outputs 0 during reset, and exactly one capture at edge SYNC_STAGES+DEBOUNCE_CYC+1 after release.
